demux4x4_stream: RTL and testbench

- 1-to-4 stream demultiplexer for 4-bit data; the distribution end of the 4:1 4-bit mux path.
- Each accepted input word goes to the output channel chosen by S, into a small per-channel FIFO.
- Sits between a single producer and four independent consumers, so back-pressure on one channel never blocks the other channels.

---
 rtl/demux4x4_stream_pkg.sv | 19 +
 rtl/demux4x4_stream_if.sv | 31 +++
 rtl/demux4x4_stream_sync_fifo.sv | 59 +++++
 rtl/demux4x4_stream.sv | 60 ++++++
 tb/tb_demux4x4_stream.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/demux4x4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Channel count, select width and occupancy-counter sizing.
package demux4x4_stream_pkg;

  localparam int NCH       = 4;
  localparam int SW        = 2;
  localparam int DEPTH_DEF = 2;

  // An occupancy counter must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CW = cnt_width(DEPTH_DEF);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [SW-1:0] sel_t;

endpackage

// File: rtl/demux4x4_stream_if.sv
// Producer-side and consumer-side stream signals of demux4x4_stream.
// The slave modport is the demultiplexer; master is its environment.
interface demux4x4_stream_if #(
  parameter int WIDTH = 4,
  parameter int CW    = demux4x4_stream_pkg::CW
);
  import demux4x4_stream_pkg::*;

  logic [WIDTH-1:0]  I;
  sel_t              S;
  logic              I_valid;
  logic              I_ready;
  logic [WIDTH-1:0]  O0;
  logic [WIDTH-1:0]  O1;
  logic [WIDTH-1:0]  O2;
  logic [WIDTH-1:0]  O3;
  logic [NCH-1:0]    O_valid;
  logic [NCH-1:0]    O_ready;
  logic [NCH*CW-1:0] CNT;

  modport master (
    output I, S, I_valid, O_ready,
    input  I_ready, O0, O1, O2, O3, O_valid, CNT
  );

  modport slave (
    input  I, S, I_valid, O_ready,
    output I_ready, O0, O1, O2, O3, O_valid, CNT
  );

endinterface

// File: rtl/demux4x4_stream_sync_fifo.sv
// Single-clock FIFO with occupancy count; the head word is read combinationally.
// Push when full and pop when empty are ignored.
module demux4x4_stream_sync_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; cnt gates its visibility, and
  // leaving it out of reset lets it map onto plain register-file cells.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/demux4x4_stream.sv
// 1-to-4 stream demultiplexer: each accepted word is queued in the FIFO of
// the channel selected by S, so a stalled consumer only blocks its own channel.
module demux4x4_stream
  import demux4x4_stream_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  demux4x4_stream_if.slave bus
);

  localparam int FIFO_CW = cnt_width(DEPTH);

  logic [NCH-1:0]     full;
  logic [NCH-1:0]     empty;
  logic [NCH-1:0]     push;
  logic [NCH-1:0]     pop;
  logic [WIDTH-1:0]   dout  [NCH];
  logic [FIFO_CW-1:0] count [NCH];
  logic               ready;

  // NOTE: every signal driven here gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    push  = '0;
    ready = !full[bus.S];
    if (bus.I_valid && ready) push[bus.S] = 1'b1;
  end

  assign pop = ~empty & bus.O_ready;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    demux4x4_stream_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RESETN),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (bus.I),
      .dout  (dout[k]),
      .full  (full[k]),
      .empty (empty[k]),
      .count (count[k])
    );

    assign bus.CNT[k*FIFO_CW +: FIFO_CW] = count[k];
  end

  assign bus.I_ready = ready;
  assign bus.O_valid = ~empty;
  assign bus.O0      = dout[0];
  assign bus.O1      = dout[1];
  assign bus.O2      = dout[2];
  assign bus.O3      = dout[3];

endmodule

// File: tb/tb_demux4x4_stream.sv
// Self-checking bench for demux4x4_stream: directed vector table, corner-case
// sequences and random traffic, all compared against per-channel queues.
module tb_demux4x4_stream;
  import demux4x4_stream_pkg::*;

  localparam int DEPTH = 2;
  localparam int W     = 4;
  localparam int CWL   = cnt_width(DEPTH);

  logic CLK    = 1'b0;
  logic RESETN = 1'b0;

  always #5 CLK = ~CLK;

  demux4x4_stream_if #(.WIDTH(W), .CW(CWL)) bus ();

  demux4x4_stream #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus.slave)
  );

  typedef logic [3:0] word_q_t [$];

  typedef struct packed {
    logic        rstn;
    logic        iv;
    logic [1:0]  s;
    logic [3:0]  i;
    logic [3:0]  ordy;
    logic        chk;
    logic [3:0]  ov;
    logic [7:0]  cnt;
    logic        irdy;
    logic [15:0] o;
  } vec_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  word_q_t    q [4];
  logic       model_ok = 1'b0;
  logic       model_acc;
  logic       cur_rstn;
  logic       cur_iv;
  logic [1:0] cur_s;
  logic [3:0] cur_i;
  logic [3:0] cur_ordy;
  logic       rec3     = 1'b0;
  word_q_t    rx3;
  int         max_cnt3 = 0;
  vec_t       tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] out_word(input int k);
    case (k)
      0:       return bus.O0;
      1:       return bus.O1;
      2:       return bus.O2;
      default: return bus.O3;
    endcase
  endfunction

  // Drive one cycle's inputs, then compare against the queue model mid-cycle.
  task automatic drive(input logic rstn, input logic iv, input logic [1:0] s,
                       input logic [3:0] i, input logic [3:0] ordy);
    logic [3:0]       exp_v;
    logic [4*CWL-1:0] exp_cnt;
    int               c3;
    cur_rstn = rstn; cur_iv = iv; cur_s = s; cur_i = i; cur_ordy = ordy;
    RESETN      = rstn;
    bus.I_valid = iv;
    bus.S       = s;
    bus.I       = i;
    bus.O_ready = ordy;
    #4;
    if (model_ok) begin
      for (int k = 0; k < 4; k++) begin
        exp_v[k]                = (q[k].size() != 0);
        exp_cnt[k*CWL +: CWL]   = CWL'(q[k].size());
      end
      check("model_o_valid", 32'(bus.O_valid), 32'(exp_v));
      check("model_cnt", 32'(bus.CNT), 32'(exp_cnt));
      check("model_i_ready", 32'(bus.I_ready), 32'(q[s].size() < DEPTH));
      for (int k = 0; k < 4; k++)
        if (exp_v[k]) check($sformatf("model_o%0d", k), 32'(out_word(k)), 32'(q[k][0]));
    end
    if (rec3 && bus.O_valid[3] && ordy[3]) rx3.push_back(bus.O3);
    c3 = int'(bus.CNT[3*CWL +: CWL]);
    if (rec3 && c3 > max_cnt3) max_cnt3 = c3;
    model_acc = model_ok && rstn && iv && (q[s].size() < DEPTH);
  endtask

  // Clock edge, then apply the same edge to the queue model.
  task automatic advance();
    logic [3:0] pops;
    @(posedge CLK);
    if (!cur_rstn) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      for (int k = 0; k < 4; k++) pops[k] = (q[k].size() != 0) && cur_ordy[k];
      for (int k = 0; k < 4; k++) if (pops[k]) void'(q[k].pop_front());
      if (model_acc) q[cur_s].push_back(cur_i);
    end
    #1;
  endtask

  task automatic cycle(input logic rstn, input logic iv, input logic [1:0] s,
                       input logic [3:0] i, input logic [3:0] ordy, output logic acc);
    drive(rstn, iv, s, i, ordy);
    acc = model_acc;
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   w;
    logic hold;

    //             rstn  iv    s     i      ordy     chk   ov       cnt    irdy  {O3,O2,O1,O0}
    tbl[0]  = '{1'b0, 1'b1, 2'd2, 4'hA, 4'b0000, 1'b0, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 4'h3, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[4]  = '{1'b1, 1'b1, 2'd1, 4'h5, 4'b1111, 1'b1, 4'b0001, 8'h01, 1'b1, 16'h0003};
    tbl[5]  = '{1'b1, 1'b1, 2'd3, 4'h9, 4'b1111, 1'b1, 4'b0010, 8'h04, 1'b1, 16'h0050};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b1000, 8'h40, 1'b1, 16'h9000};
    tbl[7]  = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 2'd1, 4'h1, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 2'd1, 4'h2, 4'b0000, 1'b1, 4'b0010, 8'h04, 1'b1, 16'h0010};
    tbl[10] = '{1'b1, 1'b1, 2'd1, 4'hF, 4'b0000, 1'b1, 4'b0010, 8'h08, 1'b0, 16'h0010};
    tbl[11] = '{1'b1, 1'b1, 2'd2, 4'h7, 4'b0000, 1'b1, 4'b0010, 8'h08, 1'b1, 16'h0010};
    tbl[12] = '{1'b1, 1'b1, 2'd1, 4'hF, 4'b0010, 1'b1, 4'b0110, 8'h18, 1'b0, 16'h0710};
    tbl[13] = '{1'b1, 1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, 4'b0110, 8'h14, 1'b1, 16'h0720};
    tbl[14] = '{1'b1, 1'b0, 2'd1, 4'h0, 4'b0100, 1'b1, 4'b0100, 8'h10, 1'b1, 16'h0700};
    tbl[15] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[16] = '{1'b1, 1'b1, 2'd0, 4'h4, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};
    tbl[17] = '{1'b1, 1'b1, 2'd0, 4'h6, 4'b0001, 1'b1, 4'b0001, 8'h01, 1'b1, 16'h0004};
    tbl[18] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0001, 8'h01, 1'b1, 16'h0006};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, 4'b0001, 8'h01, 1'b1, 16'h0006};
    tbl[20] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000, 8'h00, 1'b1, 16'h0000};

    bus.I_valid = 1'b0;
    bus.S       = '0;
    bus.I       = '0;
    bus.O_ready = '0;
    @(posedge CLK);
    #1;

    for (int r = 0; r < 21; r++) begin
      drive(tbl[r].rstn, tbl[r].iv, tbl[r].s, tbl[r].i, tbl[r].ordy);
      if (tbl[r].chk) begin
        check($sformatf("vec%0d_o_valid", r), 32'(bus.O_valid), 32'(tbl[r].ov));
        check($sformatf("vec%0d_cnt", r), 32'(bus.CNT), 32'(tbl[r].cnt));
        check($sformatf("vec%0d_i_ready", r), 32'(bus.I_ready), 32'(tbl[r].irdy));
        for (int k = 0; k < 4; k++)
          if (tbl[r].ov[k])
            check($sformatf("vec%0d_o%0d", r, k), 32'(out_word(k)), 32'(tbl[r].o[k*4 +: 4]));
      end
      advance();
    end

    // Wrap-around on channel 3 with a consumer that is ready every other cycle.
    w    = 0;
    rec3 = 1'b1;
    for (int c = 0; c < 80 && rx3.size() < 10; c++) begin
      cycle(1'b1, w < 10, 2'd3, 4'(w), (c % 2 == 1) ? 4'b1000 : 4'b0000, acc);
      if (acc) w++;
    end
    rec3 = 1'b0;
    check("wrap_word_count", 32'(rx3.size()), 32'd10);
    for (int j = 0; j < 10; j++)
      if (j < rx3.size()) check($sformatf("wrap_word%0d", j), 32'(rx3[j]), 32'(j));
    check("wrap_cnt3_le_2", 32'(max_cnt3 <= 2), 32'd1);

    // Mid-stream reset: stored words vanish, handshakes in the reset cycle are ignored.
    cycle(1'b1, 1'b1, 2'd0, 4'h1, 4'b0000, acc);
    cycle(1'b1, 1'b1, 2'd0, 4'h2, 4'b0000, acc);
    cycle(1'b1, 1'b1, 2'd2, 4'h3, 4'b0000, acc);
    cycle(1'b1, 1'b1, 2'd2, 4'h4, 4'b0000, acc);
    cycle(1'b0, 1'b1, 2'd0, 4'hE, 4'b1111, acc);
    drive(1'b1, 1'b1, 2'd0, 4'hB, 4'b0000);
    check("rst_mid_o_valid", 32'(bus.O_valid), 32'd0);
    check("rst_mid_cnt", 32'(bus.CNT), 32'd0);
    advance();
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b0001);
    check("rst_mid_o0_valid", 32'(bus.O_valid[0]), 32'd1);
    check("rst_mid_o0_first", 32'(bus.O0), 32'hB);
    advance();

    // Random traffic; the source holds I/S while it is stalled.
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic       rr;
      logic       iv;
      logic [1:0] s;
      logic [3:0] i;
      rr = ($urandom_range(0, 49) != 0);
      if (hold) begin
        iv = 1'b1; s = cur_s; i = cur_i;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        s  = 2'($urandom_range(0, 3));
        i  = 4'($urandom_range(0, 15));
      end
      cycle(rr, iv, s, i, 4'($urandom_range(0, 15)), acc);
      hold = rr && iv && !acc;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
